// File: rtl/fp_div_seq.sv
// fp_div_seq: multi-cycle IEEE-754 divider, radix-2 restoring, one quotient
// bit per clock, round-to-nearest-even, subnormal inputs treated as zero and
// tiny results flushed to zero.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake; a, b captured on transfer
//   a, b                 dividend and divisor (W = 1+EXP_W+MAN_W bits)
//   out_valid/out_ready  result handshake; result and flags held until taken
//   result               quotient a/b
//   flags                {NV, DZ, OF, UF, NX}
module fp_div_seq #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [4:0]             flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int QW   = MAN_W + 3;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(QW + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_DIVIDE = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic [CW-1:0]        CNT_INIT = CW'(QW);

  // State and datapath registers
  logic [2:0]              state_q, state_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d;
  logic                    sign_q, sign_d;
  logic signed [EW-1:0]    e_q, e_d;
  logic [MAN_W:0]          mb_q, mb_d;
  logic [MAN_W+1:0]        r_q, r_d;
  logic [QW-1:0]           quo_q, quo_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [W-1:0]            result_q, result_d;
  logic [4:0]              flags_q, flags_d;

  // Operand classification (from the latched operands)
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic sign_u, special;

  assign ea     = a_q[W-2 -: EXP_W];
  assign eb     = b_q[W-2 -: EXP_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  // Exponent zero covers both true zeros and subnormals (flushed on input)
  assign a_zero = !(|ea);
  assign b_zero = !(|eb);
  assign sign_u = a_q[W-1] ^ b_q[W-1];
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  logic [W-1:0] nan_res;
  assign nan_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // One restoring step: R never exceeds 2*mb, so MAN_W+2 bits suffice
  logic [MAN_W+1:0] mb_ext, r_sub;
  logic             q_bit;
  assign mb_ext = {1'b0, mb_q};
  assign q_bit  = (r_q >= mb_ext);
  assign r_sub  = q_bit ? (r_q - mb_ext) : r_q;

  // Normalise, round to nearest even and range-check the quotient
  logic [MAN_W-1:0]     frac_k, frac_rnd;
  logic                 guard, sticky, inc, carry, nx;
  logic signed [EW-1:0] e_adj, e_fin;
  logic [W-1:0]         rnd_result;
  logic [4:0]           rnd_flags;

  always_comb begin
    if (quo_q[QW-1]) begin
      frac_k = quo_q[QW-2:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (|r_q);
      e_adj  = e_q;
    end else begin
      // Quotient below 1.0: one extra bit of precision is available
      frac_k = quo_q[QW-3:1];
      guard  = quo_q[0];
      sticky = |r_q;
      e_adj  = e_q - E_ONE;
    end
    inc = guard && (sticky || frac_k[0]);
    // Fraction overflow means the mantissa rounded up to exactly 2.0
    {carry, frac_rnd} = {1'b0, frac_k} + {{MAN_W{1'b0}}, inc};
    e_fin = carry ? (e_adj + E_ONE) : e_adj;
    nx    = guard | sticky;
    if (e_fin >= E_MAX) begin
      rnd_result = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags  = 5'b00101;
    end else if (e_fin <= E_ZERO) begin
      rnd_result = {sign_q, {(W-1){1'b0}}};
      rnd_flags  = 5'b00011;
    end else begin
      rnd_result = {sign_q, e_fin[EXP_W-1:0], frac_rnd};
      rnd_flags  = {4'b0000, nx};
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    e_d      = e_q;
    mb_d     = mb_q;
    r_d      = r_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          flags_d = 5'b00000;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d = sign_u;
        if (special) begin
          state_d = S_DONE;
          if (a_nan || b_nan) begin
            result_d = nan_res;
            flags_d  = {a_snan | b_snan, 4'b0000};
          end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            result_d = nan_res;
            flags_d  = 5'b10000;
          end else if (a_inf) begin
            result_d = {sign_u, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d  = 5'b00000;
          end else if (b_zero) begin
            result_d = {sign_u, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d  = 5'b01000;
          end else begin
            // a is zero or b is infinite
            result_d = {sign_u, {(W-1){1'b0}}};
            flags_d  = 5'b00000;
          end
        end else begin
          mb_d    = {1'b1, fb};
          r_d     = {2'b01, fa};
          quo_d   = '0;
          e_d     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;
          cnt_d   = CNT_INIT;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        r_d   = r_sub << 1;
        quo_d = {quo_q[QW-2:0], q_bit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        result_d = rnd_result;
        flags_d  = rnd_flags;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      e_q      <= '0;
      mb_q     <= '0;
      r_q      <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      e_q      <= e_d;
      mb_q     <= mb_d;
      r_q      <= r_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: checks a double-precision and a single-precision fp_div_seq
// against an exact integer-arithmetic reference divider.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b0;
  logic [63:0] d_a = '0, d_b = '0, d_result;
  logic [4:0]  d_flags;

  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0;
  logic [31:0] s_a = '0, s_b = '0, s_result;
  logic [4:0]  s_flags;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fp_div_seq #(.EXP_W(11), .MAN_W(52)) dut_d (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .a(d_a), .b(d_b),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .result(d_result), .flags(d_flags)
  );

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .result(s_result), .flags(s_flags)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Exact reference: integer quotient plus remainder decides RNE directly.
  task automatic ref_div(input logic [63:0] x, input logic [63:0] y,
                         input int ew, input int mw,
                         output logic [63:0] r, output logic [4:0] f, output bit sp);
    logic [63:0]  emask, fmask, ex, ey, fx, fy, infv, zerov, nanv, sgn;
    logic [127:0] num, den, q, rem;
    bit xn, yn, xi, yi, xz, yz;
    int e, bias;
    emask = (64'd1 << ew) - 64'd1;
    fmask = (64'd1 << mw) - 64'd1;
    bias  = (1 << (ew - 1)) - 1;
    sgn   = {63'd0, x[ew+mw] ^ y[ew+mw]} << (ew + mw);
    ex = (x >> mw) & emask;  fx = x & fmask;
    ey = (y >> mw) & emask;  fy = y & fmask;
    xn = (ex == emask) && (fx != 0);  yn = (ey == emask) && (fy != 0);
    xi = (ex == emask) && (fx == 0);  yi = (ey == emask) && (fy == 0);
    xz = (ex == 0);                   yz = (ey == 0);
    infv  = sgn | (emask << mw);
    zerov = sgn;
    nanv  = (emask << mw) | (64'd1 << (mw - 1));
    sp = 1'b1;
    f  = 5'b00000;
    if (xn || yn) begin
      r = nanv;
      f[4] = (xn && fx[mw-1] == 1'b0) || (yn && fy[mw-1] == 1'b0);
    end else if ((xz && yz) || (xi && yi)) begin
      r = nanv; f = 5'b10000;
    end else if (xi) begin
      r = infv;
    end else if (yz) begin
      r = infv; f = 5'b01000;
    end else if (xz || yi) begin
      r = zerov;
    end else begin
      sp  = 1'b0;
      num = {64'd0, fx | (64'd1 << mw)};
      den = {64'd0, fy | (64'd1 << mw)};
      e   = int'(ex) - int'(ey) + bias;
      if (num < den) begin
        num = num << (mw + 1);
        e   = e - 1;
      end else begin
        num = num << mw;
      end
      q   = num / den;
      rem = num % den;
      if ((rem * 2 > den) || ((rem * 2 == den) && q[0])) q = q + 1;
      if (q == (128'd1 << (mw + 1))) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= int'(emask)) begin
        r = infv; f = 5'b00101;
      end else if (e <= 0) begin
        r = zerov; f = 5'b00011;
      end else begin
        r = sgn | (64'(e) << mw) | (q[63:0] & fmask);
        f = {4'b0000, rem != 0};
      end
    end
  endtask

  function automatic logic [63:0] rand_fp(input int ew, input int mw);
    logic [63:0] emask, fmask, frac, ex, s;
    int bias, cat;
    emask = (64'd1 << ew) - 64'd1;
    fmask = (64'd1 << mw) - 64'd1;
    bias  = (1 << (ew - 1)) - 1;
    frac  = {$urandom, $urandom} & fmask;
    s     = {63'd0, 1'($urandom_range(0, 1))};
    cat   = int'($urandom_range(0, 13));
    case (cat)
      0: begin ex = 0; if ($urandom_range(0, 1) == 1) frac = 0; end
      1: begin ex = emask; frac = 0; end
      2: begin ex = emask; if (frac == 0) frac = 1; end
      3: ex = emask - 64'd1 - 64'($urandom_range(0, 3));
      4: ex = 64'd1 + 64'($urandom_range(0, 3));
      default: ex = 64'(bias + int'($urandom_range(0, 40)) - 20);
    endcase
    return (s << (ew + mw)) | (ex << mw) | frac;
  endfunction

  task automatic do_op_d(input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] r, output logic [4:0] f, output int lat);
    d_a = x; d_b = y; d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    lat = 0;
    while (!d_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = d_result; f = d_flags;
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    $display("[TB] dbl %h / %h -> %h flags %b after %0d edges", x, y, r, f, lat);
  endtask

  task automatic do_op_s(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [4:0] f, output int lat);
    s_a = x; s_b = y; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = s_result; f = s_flags;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    $display("[TB] sgl %h / %h -> %h flags %b after %0d edges", x, y, r, f, lat);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (d_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_d_in_ready got %b want 1", d_in_ready); end
    tests_run++; if (d_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_d_out_valid got %b want 0", d_out_valid); end
    tests_run++; if (d_result !== 64'd0) begin tests_failed++; $display("FAIL reset_d_result got %h want 0", d_result); end
    tests_run++; if (d_flags !== 5'd0) begin tests_failed++; $display("FAIL reset_d_flags got %b want 0", d_flags); end
    tests_run++; if (s_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_s_in_ready got %b want 1", s_in_ready); end
    tests_run++; if (s_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_s_out_valid got %b want 0", s_out_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed_double;
    logic [63:0] ta [9] = '{64'h4018000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000,
                            64'h3FF0000000000000, 64'h0000000000000000, 64'hFFF0000000000000,
                            64'h7FEFFFFFFFFFFFFF, 64'h0010000000000000, 64'h7FF4000000000000};
    logic [63:0] tb_ [9] = '{64'h4000000000000000, 64'h4008000000000000, 64'h3FF8000000000000,
                             64'h0000000000000000, 64'h0000000000000000, 64'h4000000000000000,
                             64'h3FE0000000000000, 64'h4000000000000000, 64'h3FF0000000000000};
    logic [63:0] tr [9] = '{64'h4008000000000000, 64'h3FD5555555555555, 64'h3FE5555555555555,
                            64'h7FF0000000000000, 64'h7FF8000000000000, 64'hFFF0000000000000,
                            64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000};
    logic [4:0]  tf [9] = '{5'b00000, 5'b00001, 5'b00001, 5'b01000, 5'b10000,
                            5'b00000, 5'b00101, 5'b00011, 5'b10000};
    int          tl [9] = '{57, 57, 57, 1, 1, 1, 57, 57, 1};
    logic [63:0] r;
    logic [4:0]  f;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      do_op_d(ta[i], tb_[i], r, f, lat);
      tests_run++; if (r !== tr[i]) begin tests_failed++; $display("FAIL dir_d_result[%0d] got %h want %h", i, r, tr[i]); end
      tests_run++; if (f !== tf[i]) begin tests_failed++; $display("FAIL dir_d_flags[%0d] got %b want %b", i, f, tf[i]); end
      tests_run++; if (lat !== tl[i]) begin tests_failed++; $display("FAIL dir_d_latency[%0d] got %0d want %0d", i, lat, tl[i]); end
    end
  endtask

  task automatic test_handshake_back_to_back;
    logic [63:0] r0, rx, r2;
    logic [4:0]  f0, fx, f2;
    bit          sp;
    int          lat;
    // First op; in_valid stays high and operands change while busy
    d_a = 64'h4018000000000000; d_b = 64'h4000000000000000; d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_a = 64'h4059000000000000; d_b = 64'h4014000000000000;
    lat = 0;
    while (!d_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    r0 = d_result; f0 = d_flags;
    tests_run++; if (r0 !== 64'h4008000000000000) begin tests_failed++; $display("FAIL hs_result got %h want 4008000000000000", r0); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (d_out_valid !== 1'b1 || d_in_ready !== 1'b0 || d_result !== r0 || d_flags !== f0) begin
        tests_failed++;
        $display("FAIL hs_hold[%0d] got ov=%b ir=%b r=%h f=%b want ov=1 ir=0 r=%h f=%b",
                 i, d_out_valid, d_in_ready, d_result, d_flags, r0, f0);
      end
    end
    // Handoff edge: in_valid is high but must not be accepted here
    d_a = 64'h3FF0000000000000; d_b = 64'h3FF8000000000000;
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    tests_run++; if (d_out_valid !== 1'b0 || d_in_ready !== 1'b1) begin tests_failed++; $display("FAIL hs_idle got ov=%b ir=%b want ov=0 ir=1", d_out_valid, d_in_ready); end
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    d_a = 64'h4059000000000000; d_b = 64'h4014000000000000;
    tests_run++; if (d_in_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept got ir=%b want 0", d_in_ready); end
    lat = 0;
    while (!d_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    r2 = d_result; f2 = d_flags;
    ref_div(64'h3FF0000000000000, 64'h3FF8000000000000, 11, 52, rx, fx, sp);
    tests_run++; if (r2 !== rx || f2 !== fx) begin tests_failed++; $display("FAIL b2b_result got %h/%b want %h/%b", r2, f2, rx, fx); end
    tests_run++; if (lat !== 57) begin tests_failed++; $display("FAIL b2b_latency got %0d want 57", lat); end
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    $display("[TB] dbl b2b -> %h flags %b after %0d edges", r2, f2, lat);
  endtask

  task automatic test_random_double;
    logic [63:0] x, y, r, rx;
    logic [4:0]  f, fx;
    bit          sp;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      x = rand_fp(11, 52);
      y = rand_fp(11, 52);
      ref_div(x, y, 11, 52, rx, fx, sp);
      do_op_d(x, y, r, f, lat);
      tests_run++; if (r !== rx) begin tests_failed++; $display("FAIL rnd_d_result %h/%h got %h want %h", x, y, r, rx); end
      tests_run++; if (f !== fx) begin tests_failed++; $display("FAIL rnd_d_flags %h/%h got %b want %b", x, y, f, fx); end
      tests_run++; if (lat !== (sp ? 1 : 57)) begin tests_failed++; $display("FAIL rnd_d_latency got %0d want %0d", lat, sp ? 1 : 57); end
    end
  endtask

  task automatic test_single;
    logic [31:0] r;
    logic [63:0] rx;
    logic [4:0]  f, fx;
    bit          sp;
    int          lat;
    logic [31:0] x, y;
    do_op_s(32'h40400000, 32'h3F800000, r, f, lat);
    tests_run++; if (r !== 32'h40400000 || f !== 5'b00000) begin tests_failed++; $display("FAIL s_3div1 got %h/%b want 40400000/00000", r, f); end
    tests_run++; if (lat !== 28) begin tests_failed++; $display("FAIL s_latency got %0d want 28", lat); end
    do_op_s(32'h3F800000, 32'h40400000, r, f, lat);
    tests_run++; if (r !== 32'h3EAAAAAB || f !== 5'b00001) begin tests_failed++; $display("FAIL s_1div3 got %h/%b want 3eaaaaab/00001", r, f); end
    do_op_s(32'hBF800000, 32'h00000000, r, f, lat);
    tests_run++; if (r !== 32'hFF800000 || f !== 5'b01000 || lat !== 1) begin tests_failed++; $display("FAIL s_divzero got %h/%b/%0d want ff800000/01000/1", r, f, lat); end
    for (int i = 0; i < 60; i++) begin
      x = rand_fp(8, 23)[31:0];
      y = rand_fp(8, 23)[31:0];
      ref_div({32'd0, x}, {32'd0, y}, 8, 23, rx, fx, sp);
      do_op_s(x, y, r, f, lat);
      tests_run++; if (r !== rx[31:0]) begin tests_failed++; $display("FAIL rnd_s_result %h/%h got %h want %h", x, y, r, rx[31:0]); end
      tests_run++; if (f !== fx) begin tests_failed++; $display("FAIL rnd_s_flags %h/%h got %b want %b", x, y, f, fx); end
      tests_run++; if (lat !== (sp ? 1 : 28)) begin tests_failed++; $display("FAIL rnd_s_latency got %0d want %0d", lat, sp ? 1 : 28); end
    end
  endtask

  task automatic test_reset_mid_divide;
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
    bit          seen;
    s_a = 32'h40400000; s_b = 32'h3F800000; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_reset got ov=%b ir=%b want ov=0 ir=1", s_out_valid, s_in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (s_out_valid) seen = 1'b1;
    end
    tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_emit got out_valid=1 want none"); end
    do_op_s(32'h40E00000, 32'h40000000, r, f, lat);
    tests_run++; if (r !== 32'h40600000 || f !== 5'b00000 || lat !== 28) begin tests_failed++; $display("FAIL post_reset got %h/%b/%0d want 40600000/00000/28", r, f, lat); end
  endtask

  initial begin
    test_reset();
    test_directed_double();
    test_handshake_back_to_back();
    test_random_double();
    test_single();
    test_reset_mid_divide();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
